// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: the width of the op select
// and the encodings of the eight bitwise operations.
package logic_unit_pkg;

  localparam int LOGIC_OP_W = 3;

  typedef logic [LOGIC_OP_W-1:0] logic_op_t;

  localparam logic_op_t LOGIC_AND  = 3'd0;
  localparam logic_op_t LOGIC_OR   = 3'd1;
  localparam logic_op_t LOGIC_XOR  = 3'd2;
  localparam logic_op_t LOGIC_NOR  = 3'd3;
  localparam logic_op_t LOGIC_ANDN = 3'd4;
  localparam logic_op_t LOGIC_ORN  = 3'd5;
  localparam logic_op_t LOGIC_XNOR = 3'd6;
  localparam logic_op_t LOGIC_PASS = 3'd7;

endpackage

// File: rtl/pipe_logic_unit_if.sv
// Handshake bundle of the logic unit: the issue side (operands, op, tag, flush)
// and the retire side (result, tag, zero flag).
interface pipe_logic_unit_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic_op_t        op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport master (
    output flush, in_valid, op, a, b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, out_zero
  );

  modport slave (
    input  flush, in_valid, op, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, out_zero
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise operator: selects one of eight logic functions of a and b.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic_op_t        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves y unassigned (no latch).
    y = a;
    unique case (op)
      LOGIC_AND:  y = a & b;
      LOGIC_OR:   y = a | b;
      LOGIC_XOR:  y = a ^ b;
      LOGIC_NOR:  y = ~(a | b);
      LOGIC_ANDN: y = a & ~b;
      LOGIC_ORN:  y = a | ~b;
      LOGIC_XNOR: y = ~(a ^ b);
      LOGIC_PASS: y = a;
    endcase
  end

endmodule

// File: rtl/pipe_logic_unit.sv
// Pipelined bitwise logic unit with valid/ready stall chain, flush and tag sideband.
// Define LOGIC_UNIT_FLAGS_EN to carry a registered zero flag alongside each result.
module pipe_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  pipe_logic_unit_if.slave  bus
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [WIDTH-1:0] op_y;
  logic             accept;
  logic             tail_full;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (bus.op),
    .a  (bus.a),
    .b  (bus.b),
    .y  (op_y)
  );

  // A stage can load unless it and every stage after it are full while the consumer stalls.
  always_comb begin
    tail_full = 1'b1;
    rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      rdy[i]    = ~tail_full | bus.out_ready;
    end
  end

  assign bus.in_ready = rdy[0] & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic [DEPTH-1:0] zf;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          // NOTE: data/tag regs are reset too, because result and out_tag must read 0 during reset.
          v[0]      <= 1'b0;
          data_q[0] <= '0;
          tag_q[0]  <= '0;
`ifdef LOGIC_UNIT_FLAGS_EN
          zf[0]     <= 1'b0;
`endif
        end else begin
          // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
          if (bus.flush)  v[0] <= 1'b0;
          else if (rdy[0]) v[0] <= accept;
          if (accept) begin
            data_q[0] <= op_y;
            tag_q[0]  <= bus.in_tag;
`ifdef LOGIC_UNIT_FLAGS_EN
            zf[0]     <= (op_y == '0);
`endif
          end
        end
      end
    end else begin : g_hold
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v[i]      <= 1'b0;
          data_q[i] <= '0;
          tag_q[i]  <= '0;
`ifdef LOGIC_UNIT_FLAGS_EN
          zf[i]     <= 1'b0;
`endif
        end else begin
          if (bus.flush)   v[i] <= 1'b0;
          else if (rdy[i]) v[i] <= v[i-1];
          // Data only moves with a valid op so an empty output stage holds still.
          if (rdy[i] && v[i-1]) begin
            data_q[i] <= data_q[i-1];
            tag_q[i]  <= tag_q[i-1];
`ifdef LOGIC_UNIT_FLAGS_EN
            zf[i]     <= zf[i-1];
`endif
          end
        end
      end
    end
  end

  assign bus.out_valid = v[DEPTH-1];
  assign bus.result    = data_q[DEPTH-1];
  assign bus.out_tag   = tag_q[DEPTH-1];

`ifdef LOGIC_UNIT_FLAGS_EN
  assign bus.out_zero  = zf[DEPTH-1];
`else
  assign bus.out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_logic_unit.sv
// Directed bench for pipe_logic_unit: op table at W=32/D=2, stall, flush,
// async reset mid-stream, and a W=8/D=1 instance.
module tb_pipe_logic_unit;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_logic_unit_if #(.WIDTH(32), .TAG_W(5)) bus  ();
  pipe_logic_unit_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

  pipe_logic_unit #(.WIDTH(32), .DEPTH(2), .TAG_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_logic_unit #(.WIDTH(8), .DEPTH(1), .TAG_W(5)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_zero(input logic [31:0] r);
`ifdef LOGIC_UNIT_FLAGS_EN
    return (r == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic vld, input logic_op_t o, input logic [31:0] da,
                       input logic [31:0] db, input logic [4:0] t);
    bus.in_valid = vld;
    bus.op       = o;
    bus.a        = da;
    bus.b        = db;
    bus.in_tag   = t;
  endtask

  task automatic drive8(input logic vld, input logic_op_t o, input logic [7:0] da,
                        input logic [7:0] db, input logic [4:0] t);
    bus8.in_valid = vld;
    bus8.op       = o;
    bus8.a        = da;
    bus8.b        = db;
    bus8.in_tag   = t;
  endtask

  typedef struct {
    logic_op_t   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{LOGIC_AND,  32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF000_000F};
    vecs[1]  = '{LOGIC_OR,   32'hF0F0_00FF, 32'hFF00_0F0F, 32'hFFF0_0FFF};
    vecs[2]  = '{LOGIC_XOR,  32'hF0F0_00FF, 32'hFF00_0F0F, 32'h0FF0_0FF0};
    vecs[3]  = '{LOGIC_NOR,  32'hF0F0_00FF, 32'hFF00_0F0F, 32'h000F_F000};
    vecs[4]  = '{LOGIC_ANDN, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h00F0_00F0};
    vecs[5]  = '{LOGIC_ORN,  32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF0FF_F0FF};
    vecs[6]  = '{LOGIC_XNOR, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF00F_F00F};
    vecs[7]  = '{LOGIC_PASS, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF0F0_00FF};
    vecs[8]  = '{LOGIC_XOR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[9]  = '{LOGIC_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[10] = '{LOGIC_ANDN, 32'hFFFF_FFFF, 32'h1234_5678, 32'hEDCB_A987};
    vecs[11] = '{LOGIC_AND,  32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608};
    vecs[12] = '{LOGIC_XNOR, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hFFFF_FFFF};
    vecs[13] = '{LOGIC_ORN,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[14] = '{LOGIC_OR,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1;
    bus.flush = 1'b0;  bus.out_ready = 1'b1;  drive(1'b0, LOGIC_AND, '0, '0, '0);
    bus8.flush = 1'b0; bus8.out_ready = 1'b1; drive8(1'b0, LOGIC_AND, '0, '0, '0);

    // Reset state
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result",    bus.result,    0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_out_zero",  bus.out_zero,  0);
    check("rst8_out_valid", bus8.out_valid, 0);
    #10;
    @(negedge clk);
    rst = 1'b0;

    // Op table, back-to-back, latency 2
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("tbl_valid_%0d", i - 2), bus.out_valid, 1);
        check($sformatf("tbl_result_%0d", i - 2), bus.result, vecs[i-2].exp);
        check($sformatf("tbl_tag_%0d", i - 2), bus.out_tag, i - 2);
        check($sformatf("tbl_zero_%0d", i - 2), bus.out_zero, exp_zero(vecs[i-2].exp));
      end else begin
        check($sformatf("tbl_lead_empty_%0d", i), bus.out_valid, 0);
      end
      if (i < NV) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i));
      else        drive(1'b0, LOGIC_AND, '0, '0, '0);
      #1 check($sformatf("tbl_in_ready_%0d", i), bus.in_ready, 1);
    end
    @(negedge clk);
    check("tbl_drained", bus.out_valid, 0);

    // Stall: fill with out_ready low, hold 5 cycles, then drain
    bus.out_ready = 1'b0;
    drive(1'b1, LOGIC_PASS, 32'hA0, '0, 5'd10);
    #1 check("stall_ready_empty", bus.in_ready, 1);
    @(negedge clk);
    drive(1'b1, LOGIC_PASS, 32'hA1, '0, 5'd11);
    #1 check("stall_ready_bubble", bus.in_ready, 1);
    @(negedge clk);
    drive(1'b1, LOGIC_PASS, 32'hA2, '0, 5'd12);
    #1 check("stall_ready_full", bus.in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d", k), bus.out_valid, 1);
      check($sformatf("stall_tag_%0d", k), bus.out_tag, 10);
      check($sformatf("stall_result_%0d", k), bus.result, 32'hA0);
      #1 check($sformatf("stall_in_ready_%0d", k), bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    check("release_tag_10", bus.out_tag, 10);
    #1 check("release_in_ready", bus.in_ready, 1);
    for (int k = 11; k <= 12; k++) begin
      @(negedge clk);
      drive(1'b0, LOGIC_AND, '0, '0, '0);
      check($sformatf("release_valid_%0d", k), bus.out_valid, 1);
      check($sformatf("release_tag_%0d", k), bus.out_tag, k);
      check($sformatf("release_result_%0d", k), bus.result, 32'hA0 + k - 10);
    end
    @(negedge clk);
    check("release_drained", bus.out_valid, 0);

    // Flush with in_valid high while the head op retires
    drive(1'b1, LOGIC_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd20);
    @(negedge clk);
    drive(1'b1, LOGIC_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd21);
    @(negedge clk);
    check("flush_pre_valid", bus.out_valid, 1);
    check("flush_pre_tag",   bus.out_tag,   20);
    bus.flush = 1'b1;
    drive(1'b1, LOGIC_PASS, 32'h22, '0, 5'd22);
    #1 check("flush_in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_cleared", bus.out_valid, 0);
    drive(1'b1, LOGIC_OR, 32'h1, 32'h2, 5'd23);
    @(negedge clk);
    drive(1'b0, LOGIC_AND, '0, '0, '0);
    check("flush_post_lat1", bus.out_valid, 0);
    @(negedge clk);
    check("flush_post_valid",  bus.out_valid, 1);
    check("flush_post_tag",    bus.out_tag,   23);
    check("flush_post_result", bus.result,    32'h3);
    @(negedge clk);
    check("flush_post_drained", bus.out_valid, 0);

    // Async reset with two ops in flight
    drive(1'b1, LOGIC_XOR, 32'h1234_0000, 32'h0000_5678, 5'd5);
    @(negedge clk);
    drive(1'b1, LOGIC_PASS, 32'h6666_6666, '0, 5'd6);
    @(negedge clk);
    drive(1'b0, LOGIC_AND, '0, '0, '0);
    check("mid_valid_before_rst", bus.out_valid, 1);
    check("mid_result_before_rst", bus.result, 32'h1234_5678);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid",  bus.out_valid, 0);
    check("mid_rst_result", bus.result,    0);
    check("mid_rst_tag",    bus.out_tag,   0);
    check("mid_rst_zero",   bus.out_zero,  0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    check("post_rst_no_ghost", bus.out_valid, 0);

    // WIDTH=8, DEPTH=1 instance
    drive8(1'b1, LOGIC_NOR, 8'h0F, 8'h30, 5'd3);
    @(negedge clk);
    check("w8_valid_nor",  bus8.out_valid, 1);
    check("w8_result_nor", bus8.result,    8'hC0);
    check("w8_tag_nor",    bus8.out_tag,   3);
    drive8(1'b1, LOGIC_AND, 8'hFF, 8'h3C, 5'd4);
    @(negedge clk);
    check("w8_result_and", bus8.result,  8'h3C);
    check("w8_tag_and",    bus8.out_tag, 4);
    bus8.out_ready = 1'b0;
    drive8(1'b1, LOGIC_NOR, 8'h00, 8'h00, 5'd7);
    #1 check("w8_stall_in_ready", bus8.in_ready, 0);
    @(negedge clk);
    check("w8_stall_tag",    bus8.out_tag, 4);
    check("w8_stall_result", bus8.result,  8'h3C);
    bus8.out_ready = 1'b1;
    #1 check("w8_release_in_ready", bus8.in_ready, 1);
    @(negedge clk);
    drive8(1'b0, LOGIC_AND, '0, '0, '0);
    check("w8_result_last", bus8.result,  8'hFF);
    check("w8_tag_last",    bus8.out_tag, 7);
    @(negedge clk);
    check("w8_drained", bus8.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
